calc_key_entry: RTL and testbench
=================================

# calc_key_entry

Converts the decoded keypad stream from the PS/2 keyboard decoder into complete calculator commands. It filters key releases, assembles two decimal operands and an operator, and presents the result on a valid/ready command port. The command port feeds the ARM-side calculator datapath. The block also drives a display value for the operand currently being typed.

## Interface
Parameters:
- W, 16, operand width in bits. Must satisfy 2^W > 10^MAX_DIGITS − 1.
- MAX_DIGITS, 4, maximum decimal digits per operand.

Ports:
- CLK  in  1  system clock. This is the only clock.
- RESET_N  in  1  asynchronous active-low reset.
- key_code  in  5  decoder output: 0–9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 ENTER, 15 ESC, 16 none. Values 17–31 are treated as none.
- cmd_ready  in  1  consumer accepts the command.
- cmd_valid  out  1  command available.
- cmd_a  out  W  operand A, binary.
- cmd_b  out  W  operand B, binary.
- cmd_op  out  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- disp_value  out  W  operand being entered.
- disp_state  out  2  current FSM state encoding.

## Operation
- Event detect:
  - An event occurs in cycle t when key_code(t) ≤ 15 and key_code(t−1) is none.
  - After reset, the previous value is treated as none.
  - A code held for many cycles produces exactly one event.
- Release filter:
  - Each keypress reaches this block twice (make, then release).
  - Registers: last_code (4 bits) and rel_pend (1 bit). rel_pend resets to 0.
  - If an event code equals last_code while rel_pend=1, the event is dropped and rel_pend is cleared.
  - Otherwise the event is accepted, last_code is set to the code, and rel_pend is set to 1.
- Digit append: acc ← acc·10 + d, computed as (acc<<3)+(acc<<1)+d.
  - Only performed when the operand's digit count < MAX_DIGITS.
  - Additional digits are dropped silently.
- FSM states: S_A=0, S_B=1, S_ISSUE=2.
- S_A:
  - digit: append to A.
  - operator: latch op and go to S_B. A stays 0 if no digits were entered.
  - ENTER: ignored.
  - ESC: clear A, B, op and digit counts; stay in S_A.
- S_B:
  - digit: append to B.
  - operator: replaces op; B is unchanged.
  - ENTER: go to S_ISSUE if the B digit count ≥ 1, otherwise ignored.
  - ESC: full clear, go to S_A.
- S_ISSUE:
  - cmd_valid=1; cmd_a, cmd_b and cmd_op are held stable.
  - All key events are consumed through the release filter but have no other effect. ESC does not abort.
  - On the edge where cmd_valid and cmd_ready are both 1: full clear and go to S_A.
- disp_value shows A in S_A, B in S_B, and B in S_ISSUE.
- Reset values: state S_A; A, B, op and digit counts 0; cmd_valid 0; cmd_a, cmd_b, disp_value 0; cmd_op 0; last_code 0; rel_pend 0.

## Timing
- All state updates occur on the CLK rising edge.
- Event sampled in cycle t: the effect is visible on disp_value and disp_state in cycle t+1.
- Accepted ENTER in cycle t: cmd_valid=1 from cycle t+1.
- Handshake:
  - cmd_valid never drops without a handshake, except on reset.
  - Handshake on the edge ending cycle t: cmd_valid=0 and disp_value=0 in t+1.
  - cmd_ready may be high before cmd_valid. The command is then consumed on the first cycle valid is high, so valid is high for exactly one cycle.
- Simultaneous event and handshake in S_ISSUE: the handshake wins, the event is only filtered, and the next state is S_A.
- RESET_N low at any time, including mid-S_ISSUE: all outputs take their reset values immediately, without waiting for a clock edge.
- Throughput: at most one accepted event per 2 cycles, which follows from the none-gap required between events.

## Structure
- Shared package calc_pkg:
  - key code constants KEY_ADD=10 … KEY_ESC=15, KEY_NONE=16.
  - op_t enum {OP_ADD, OP_SUB, OP_MUL, OP_DIV}.
  - state_t enum {S_A, S_B, S_ISSUE}.
- Sub-module key_event_filter:
  - Contains the edge detect and the release filter.
  - Outputs ev_valid (1 cycle) and ev_code (4 bits).
- The top level holds the FSM, the accumulators and the command register.

## Test plan
- Sequence 1,1,2,2,+,+,3,3,ENTER,ENTER with none between codes and cmd_ready=1 → one cmd_valid pulse with cmd_a=12, cmd_b=3, cmd_op=0.
- Same sequence with cmd_ready=0 for 20 cycles, extra keys 5,5 sent meanwhile → cmd_valid and the command stay stable. Then cmd_ready=1 → cmd_valid=0 the next cycle, disp_value=0, disp_state=S_A.
- Digits 1,2,3,4,5 (each press+release) → disp_value=1234.
- 7,*,8 then ESC → disp_state=S_A, disp_value=0, no cmd_valid. key_code held at 7 for 50 cycles, then released → counts as one event.
- 9,+,−,ENTER (no B digits) → ENTER ignored. Then 4,ENTER → cmd_a=9, cmd_b=4, cmd_op=1.
- RESET_N asserted while in S_ISSUE → cmd_valid=0 with no clock edge required. After release, 3 press/release updates disp_value to 3.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry block.
// Contents: key code constants, operator and FSM state enums, and small
// helpers that classify a 4-bit key event code.
package calc_pkg;

  localparam logic [4:0] KEY_ADD   = 5'd10;
  localparam logic [4:0] KEY_SUB   = 5'd11;
  localparam logic [4:0] KEY_MUL   = 5'd12;
  localparam logic [4:0] KEY_DIV   = 5'd13;
  localparam logic [4:0] KEY_ENTER = 5'd14;
  localparam logic [4:0] KEY_ESC   = 5'd15;
  localparam logic [4:0] KEY_NONE  = 5'd16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code >= KEY_ADD[3:0]) && (code <= KEY_DIV[3:0]);
  endfunction

endpackage

// File: rtl/key_event_filter.sv
// Turns the raw decoder stream into single-cycle key events and drops the
// release copy of each keypress.
// Ports:
//   CLK, RESET_N - clock, async active-low reset
//   key_code     - decoder output; any value >= 16 means "no key"
//   ev_valid     - one-cycle pulse for an accepted (make) event
//   ev_code      - code of the event, valid with ev_valid
module key_event_filter
  import calc_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [4:0] key_code,
  output logic       ev_valid,
  output logic [3:0] ev_code
);

  logic       prev_none_q;
  logic [3:0] last_code_q;
  logic       rel_pend_q;

  logic code_is_none;
  logic raw_ev;
  logic is_release;

  // Codes 16..31 all have bit 4 set, so bit 4 alone identifies "none".
  assign code_is_none = key_code[4];
  assign raw_ev       = !code_is_none && prev_none_q;
  // Second occurrence of the same code right after a make is its release.
  assign is_release   = raw_ev && rel_pend_q && (key_code[3:0] == last_code_q);

  assign ev_valid = raw_ev && !is_release;
  assign ev_code  = key_code[3:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_none_q <= 1'b1;
      last_code_q <= 4'd0;
      rel_pend_q  <= 1'b0;
    end else begin
      prev_none_q <= code_is_none;
      if (raw_ev) begin
        if (is_release) begin
          rel_pend_q <= 1'b0;
        end else begin
          last_code_q <= key_code[3:0];
          rel_pend_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Calculator key entry: assembles operand A, operator and operand B from
// filtered key events and offers the result on a valid/ready command port.
// Ports:
//   CLK, RESET_N       - clock, async active-low reset
//   key_code           - decoded keypad stream
//   cmd_ready          - consumer accepts the command
//   cmd_valid          - command available (high throughout S_ISSUE)
//   cmd_a/cmd_b/cmd_op - command payload
//   disp_value         - operand currently being entered
//   disp_state         - FSM state encoding
//
// state   | meaning
// S_A     | entering operand A
// S_B     | entering operand B (operator latched)
// S_ISSUE | command presented, waiting for cmd_ready
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [4:0]   key_code,
  input  logic         cmd_ready,
  output logic         cmd_valid,
  output logic [W-1:0] cmd_a,
  output logic [W-1:0] cmd_b,
  output logic [1:0]   cmd_op,
  output logic [W-1:0] disp_value,
  output logic [1:0]   disp_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

  logic         ev_valid;
  logic [3:0]   ev_code;
  logic [3:0]   op_off;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  op_t           op_q, op_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  key_event_filter u_filter (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .key_code (key_code),
    .ev_valid (ev_valid),
    .ev_code  (ev_code)
  );

  function automatic logic [W-1:0] append_digit(input logic [W-1:0] acc,
                                                input logic [3:0]   d);
    return (acc << 3) + (acc << 1) + W'(d);
  endfunction

  // Operator codes 10..13 map onto OP_ADD..OP_DIV.
  assign op_off = ev_code - 4'd10;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    case (state_q)
      S_A: begin
        if (ev_valid) begin
          if (is_digit(ev_code)) begin
            if (cnt_a_q < MAXD) begin
              a_d     = append_digit(a_q, ev_code);
              cnt_a_d = cnt_a_q + CW'(1);
            end
          end else if (is_operator(ev_code)) begin
            op_d    = op_t'(op_off[1:0]);
            state_d = S_B;
          end else if (ev_code == KEY_ESC[3:0]) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            cnt_a_d = '0;
            cnt_b_d = '0;
          end
        end
      end
      S_B: begin
        if (ev_valid) begin
          if (is_digit(ev_code)) begin
            if (cnt_b_q < MAXD) begin
              b_d     = append_digit(b_q, ev_code);
              cnt_b_d = cnt_b_q + CW'(1);
            end
          end else if (is_operator(ev_code)) begin
            op_d = op_t'(op_off[1:0]);
          end else if (ev_code == KEY_ENTER[3:0]) begin
            if (cnt_b_q != '0) state_d = S_ISSUE;
          end else begin
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = S_A;
          end
        end
      end
      S_ISSUE: begin
        // Key events are swallowed here; only the handshake leaves.
        if (cmd_ready) begin
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          cnt_a_d = '0;
          cnt_b_d = '0;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  // Outputs come straight from registers so reset clears them immediately.
  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_a      = a_q;
  assign cmd_b      = b_q;
  assign cmd_op     = op_q;
  assign disp_value = (state_q == S_A) ? a_q : b_q;
  assign disp_state = state_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: key sequences with hand-computed
// expected command, display and state values.
module tb_calc_key_entry;

  localparam int W = 16;

  logic         CLK;
  logic         RESET_N;
  logic [4:0]   key_code;
  logic         cmd_ready;
  logic         cmd_valid;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [1:0]   cmd_op;
  logic [W-1:0] disp_value;
  logic [1:0]   disp_state;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_count = 0;

  calc_key_entry #(.W(W), .MAX_DIGITS(4)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .key_code   (key_code),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .disp_value (disp_value),
    .disp_state (disp_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RESET_N && cmd_valid && cmd_ready) hs_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a code for 'hold' cycles followed by none; returns at the negedge
  // after the event edge, where its effect is observable.
  task automatic send(input logic [4:0] c, input int hold = 1);
    @(negedge CLK) key_code = c;
    repeat (hold - 1) @(negedge CLK);
    @(negedge CLK) key_code = 5'd16;
  endtask

  // make + release
  task automatic tap(input logic [4:0] c);
    send(c);
    send(c);
  endtask

  initial begin
    RESET_N   = 1'b0;
    key_code  = 5'd16;
    cmd_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_state", disp_state, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_a", cmd_a, 0);
    chk("rst_op", cmd_op, 0);
    RESET_N = 1'b1;

    // 1: 12 + 3 ENTER with ready high -> single-cycle command
    cmd_ready = 1'b1;
    tap(1); tap(2);
    chk("t1_dispA", disp_value, 12);
    tap(10);
    chk("t1_stateB", disp_state, 1);
    tap(3);
    send(14);
    chk("t1_valid", cmd_valid, 1);
    chk("t1_a", cmd_a, 12);
    chk("t1_b", cmd_b, 3);
    chk("t1_op", cmd_op, 0);
    @(negedge CLK);
    chk("t1_valid_drop", cmd_valid, 0);
    chk("t1_state", disp_state, 0);
    send(14);
    chk("t1_hs", hs_count, 1);

    // 2: ready low while keys (incl. ESC) arrive; command must hold
    cmd_ready = 1'b0;
    tap(1); tap(2); tap(10); tap(3);
    send(14);
    send(14);
    tap(5);
    tap(15);
    repeat (8) @(negedge CLK);
    chk("t2_valid", cmd_valid, 1);
    chk("t2_state", disp_state, 2);
    chk("t2_a", cmd_a, 12);
    chk("t2_b", cmd_b, 3);
    chk("t2_op", cmd_op, 0);
    chk("t2_disp", disp_value, 3);
    cmd_ready = 1'b1;
    @(negedge CLK);
    chk("t2_valid_drop", cmd_valid, 0);
    chk("t2_disp0", disp_value, 0);
    chk("t2_stateA", disp_state, 0);
    chk("t2_hs", hs_count, 2);

    // 3: fifth digit dropped
    tap(1); tap(2); tap(3); tap(4); tap(5);
    chk("t3_disp", disp_value, 1234);
    tap(15);
    chk("t3_esc", disp_value, 0);

    // 4: ESC from S_B, long hold counts once
    tap(7); tap(12); tap(8);
    chk("t4_dispB", disp_value, 8);
    chk("t4_stateB", disp_state, 1);
    chk("t4_opmul", cmd_op, 2);
    tap(15);
    chk("t4_stateA", disp_state, 0);
    chk("t4_disp0", disp_value, 0);
    chk("t4_valid", cmd_valid, 0);
    send(7, 50);
    chk("t4_hold", disp_value, 7);
    send(7);
    chk("t4_hold_rel", disp_value, 7);
    send(7);
    chk("t4_next", disp_value, 77);
    send(7);
    tap(15);
    chk("t4_clear", disp_value, 0);

    // 5: ENTER without B digits ignored, operator replaced
    tap(9); tap(10); tap(11);
    chk("t5_op", cmd_op, 1);
    tap(14);
    chk("t5_enter_ign", disp_state, 1);
    chk("t5_novalid", cmd_valid, 0);
    tap(4);
    send(14);
    chk("t5_valid", cmd_valid, 1);
    chk("t5_a", cmd_a, 9);
    chk("t5_b", cmd_b, 4);
    chk("t5_op2", cmd_op, 1);
    send(14);
    chk("t5_hs", hs_count, 3);
    chk("t5_stateA", disp_state, 0);

    // 6: async reset during S_ISSUE
    cmd_ready = 1'b0;
    tap(1); tap(10); tap(2);
    send(14);
    chk("t6_valid", cmd_valid, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_async_valid", cmd_valid, 0);
    chk("t6_async_state", disp_state, 0);
    chk("t6_async_a", cmd_a, 0);
    chk("t6_async_disp", disp_value, 0);
    @(negedge CLK) RESET_N = 1'b1;
    tap(3);
    chk("t6_after", disp_value, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
